// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory-port arbiter.
// Optional round-robin arbitration is enabled with the ARB_RR_EN macro.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select between the instruction and data requesters.
// ARB_RR_EN: contested requests alternate using last_grant; otherwise data wins.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic inst_req,
    input  logic data_req,
`ifdef ARB_RR_EN
    input  logic last_grant,
`endif
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = inst_req | data_req;
        grant_owner = OWN_INST;
`ifdef ARB_RR_EN
        if (inst_req && data_req) begin
            grant_owner = ~last_grant;
        end else if (data_req) begin
            grant_owner = OWN_DATA;
        end
`else
        if (data_req) begin
            grant_owner = OWN_DATA;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like memory port between instruction fetch and data access.
// One transaction in flight; ARB_RR_EN selects round-robin on contested requests.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // state   | meaning
    // IDLE    | no transaction; grant the winning requester
    // ADDR    | presenting captured request to memory, waiting mem_addr_ok
    // DATA    | waiting mem_data_ok, then complete to the owner

    state_t            state, next_state;
    logic              owner;
    logic              cap_wr;
    logic [1:0]        cap_size;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              grant_valid;
    logic              grant_owner;
    logic              accept;
    logic              complete;

`ifdef ARB_RR_EN
    logic last_grant;
`endif

    arb_pick u_arb_pick (
        .inst_req    (inst_req),
        .data_req    (data_req),
`ifdef ARB_RR_EN
        .last_grant  (last_grant),
`endif
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign accept   = (state == ST_IDLE) && grant_valid;
    assign complete = (state == ST_DATA) && mem_data_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_INST;
            cap_wr    <= 1'b0;
            cap_size  <= 2'd0;
            cap_addr  <= '0;
            cap_wdata <= '0;
`ifdef ARB_RR_EN
            last_grant <= OWN_INST;
`endif
        end else begin
            state <= next_state;
            if (accept) begin
                owner     <= grant_owner;
                cap_wr    <= (grant_owner == OWN_DATA) ? data_wr    : inst_wr;
                cap_size  <= (grant_owner == OWN_DATA) ? data_size  : inst_size;
                cap_addr  <= (grant_owner == OWN_DATA) ? data_addr  : inst_addr;
                cap_wdata <= (grant_owner == OWN_DATA) ? data_wdata : inst_wdata;
`ifdef ARB_RR_EN
                last_grant <= grant_owner;
`endif
            end
        end
    end

    always_comb begin
        next_state   = state;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        mem_req      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    next_state   = ST_ADDR;
                    inst_addr_ok = (grant_owner == OWN_INST);
                    data_addr_ok = (grant_owner == OWN_DATA);
                end
            end
            ST_ADDR: begin
                mem_req = 1'b1;
                // a data_ok seen alongside addr_ok is deliberately dropped here
                if (mem_addr_ok) begin
                    next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (mem_data_ok) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Captured fields reach the port only while the request is presented.
    assign mem_wr    = mem_req ? cap_wr    : 1'b0;
    assign mem_size  = mem_req ? cap_size  : 2'd0;
    assign mem_addr  = mem_req ? cap_addr  : '0;
    assign mem_wdata = mem_req ? cap_wdata : '0;

    assign inst_data_ok = complete && (owner == OWN_INST);
    assign data_data_ok = complete && (owner == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; honours ARB_RR_EN when defined.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    // From an ADDR cycle: zero-wait memory accepts, then completes next cycle.
    task automatic finish_txn(input logic [31:0] rdata);
        mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = rdata;
        tick();
        mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        n_tests++;
        if ({mem_req, busy, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req/busy/aok/aok/dok/dok=%b want 000000",
                     {mem_req, busy, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
        n_tests++;
        if (mem_addr !== 32'h0 || mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem_fields: got addr=%h wr=%b want 0/0", mem_addr, mem_wr);
        end
        tick();
    endtask

    task automatic test_single_inst();
        inst_req = 1; inst_addr = 32'h1FC0_0000; inst_size = SZ_WORD;
        #1;
        n_tests++;
        if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL inst_accept: got iaok=%b daok=%b mreq=%b want 1 0 0",
                     inst_addr_ok, data_addr_ok, mem_req);
        end
        tick();
        inst_req = 0; inst_addr = 0;
        mem_addr_ok = 1;
        #1;
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1FC0_0000 || mem_wr !== 1'b0
            || mem_size !== SZ_WORD || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL inst_addr_phase: got req=%b addr=%h wr=%b size=%0d busy=%b want 1 1fc00000 0 2 1",
                     mem_req, mem_addr, mem_wr, mem_size, busy);
        end
        tick();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h3C1D_0000;
        #1;
        n_tests++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3C1D_0000 || data_data_ok !== 1'b0
            || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL inst_data_phase: got dok=%b rdata=%h ddok=%b mreq=%b want 1 3c1d0000 0 0",
                     inst_data_ok, inst_rdata, data_data_ok, mem_req);
        end
        tick();
        mem_data_ok = 0; mem_rdata = 0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || inst_data_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL inst_back_idle: got busy=%b dok=%b want 0 0", busy, inst_data_ok);
        end
    endtask

    task automatic test_contested();
        logic exp_inst_first;
        // Round 1: fresh after an inst grant, so data wins in both builds.
        inst_req = 1; inst_addr = 32'h1FC0_0004; inst_size = SZ_WORD;
        data_req = 1; data_wr = 1; data_addr = 32'h0000_0100; data_wdata = 32'hDEAD_BEEF;
        data_size = SZ_WORD;
        #1;
        n_tests++;
        if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL contest1_grant: got daok=%b iaok=%b want 1 0", data_addr_ok, inst_addr_ok);
        end
        tick();
        data_req = 0; data_wr = 0; data_addr = 0; data_wdata = 0;
        #1;
        n_tests++;
        if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h100
            || mem_wdata !== 32'hDEAD_BEEF || mem_size !== SZ_WORD || inst_addr_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL contest1_fields: got req=%b wr=%b addr=%h wdata=%h size=%0d iaok=%b want 1 1 100 deadbeef 2 0",
                     mem_req, mem_wr, mem_addr, mem_wdata, mem_size, inst_addr_ok);
        end
        mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; mem_data_ok = 1;
        #1;
        n_tests++;
        if (data_data_ok !== 1'b1 || inst_addr_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL contest1_complete: got ddok=%b iaok=%b idok=%b want 1 0 0",
                     data_data_ok, inst_addr_ok, inst_data_ok);
        end
        tick();
        mem_data_ok = 0;
        #1;
        n_tests++;
        if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL contest1_loser_next: got iaok=%b daok=%b want 1 0", inst_addr_ok, data_addr_ok);
        end
        tick();
        inst_req = 0;
        finish_txn(32'h0);

        // Data-only transaction so the last grant is data.
        data_req = 1; data_addr = 32'h0000_0104; data_size = SZ_WORD;
        tick();
        data_req = 0; data_addr = 0;
        finish_txn(32'h0);

        // Round 2: round-robin now favours inst; fixed priority still favours data.
`ifdef ARB_RR_EN
        exp_inst_first = 1'b1;
`else
        exp_inst_first = 1'b0;
`endif
        inst_req = 1; inst_addr = 32'h1FC0_0008;
        data_req = 1; data_addr = 32'h0000_0108;
        #1;
        n_tests++;
        if (inst_addr_ok !== exp_inst_first || data_addr_ok !== ~exp_inst_first) begin
            n_fail++;
            $display("FAIL contest2_grant: got iaok=%b daok=%b want %b %b",
                     inst_addr_ok, data_addr_ok, exp_inst_first, ~exp_inst_first);
        end
        tick();
        if (exp_inst_first) inst_req = 0; else data_req = 0;
        finish_txn(32'h0);
        #1;
        n_tests++;
        if (inst_addr_ok !== ~exp_inst_first || data_addr_ok !== exp_inst_first) begin
            n_fail++;
            $display("FAIL contest2_loser: got iaok=%b daok=%b want %b %b",
                     inst_addr_ok, data_addr_ok, ~exp_inst_first, exp_inst_first);
        end
        tick();
        inst_req = 0; data_req = 0;
        finish_txn(32'h0);
        clear_inputs();
    endtask

    task automatic test_addr_stall();
        int bad = 0;
        data_req = 1; data_addr = 32'h0000_0200; data_size = SZ_HALF;
        tick();
        data_req = 0; data_addr = 0;
        inst_req = 1; inst_addr = 32'h0000_0300;
        for (int i = 0; i < 5; i++) begin
            mem_addr_ok = (i == 4);
            #1;
            if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_size !== SZ_HALF
                || inst_addr_ok !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold cycle %0d: got req=%b addr=%h size=%0d iaok=%b busy=%b want 1 200 1 0 1",
                         i, mem_req, mem_addr, mem_size, inst_addr_ok, busy);
            end
            tick();
        end
        n_tests++;
        if (bad != 0) n_fail++;
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1234_5678;
        #1;
        n_tests++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'h1234_5678 || inst_addr_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_complete: got ddok=%b rdata=%h iaok=%b want 1 12345678 0",
                     data_data_ok, data_rdata, inst_addr_ok);
        end
        tick();
        mem_data_ok = 0; mem_rdata = 0;
        #1;
        n_tests++;
        if (inst_addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_next_grant: got iaok=%b want 1", inst_addr_ok);
        end
        tick();
        inst_req = 0;
        finish_txn(32'h0);
        clear_inputs();
    endtask

    task automatic test_rst_mid();
        data_req = 1; data_addr = 32'h0000_0400; data_size = SZ_WORD;
        tick();
        data_req = 0; data_addr = 0;
        mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0;
        rst = 1;
        tick();
        rst = 0;
        mem_data_ok = 1; mem_rdata = 32'hAAAA_5555;
        #1;
        n_tests++;
        if ({busy, mem_req, inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok} !== 6'b0
            || data_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_late_dok: got busy/req/idok/ddok/iaok/daok=%b rdata=%h want 000000 0",
                     {busy, mem_req, inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok}, data_rdata);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_spurious();
        mem_data_ok = 1; mem_rdata = 32'h5555_AAAA;
        #1;
        n_tests++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_idle: got idok=%b ddok=%b busy=%b want 0 0 0",
                     inst_data_ok, data_data_ok, busy);
        end
        tick();
        mem_data_ok = 0; mem_rdata = 0;
        inst_req = 1; inst_addr = 32'h0000_0040;
        tick();
        inst_req = 0; inst_addr = 0;
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h0BAD_0BAD;
        #1;
        n_tests++;
        if (inst_data_ok !== 1'b0 || mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_addr_both: got idok=%b mreq=%b want 0 1", inst_data_ok, mem_req);
        end
        tick();
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        #1;
        n_tests++;
        if (busy !== 1'b1 || mem_req !== 1'b0 || inst_data_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_in_data: got busy=%b mreq=%b idok=%b want 1 0 0",
                     busy, mem_req, inst_data_ok);
        end
        tick();
        mem_data_ok = 1; mem_rdata = 32'hC0DE_0001;
        #1;
        n_tests++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hC0DE_0001 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_real_dok: got idok=%b rdata=%h busy=%b want 1 c0de0001 1",
                     inst_data_ok, inst_rdata, busy);
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_end_idle: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_single_inst();
        test_contested();
        test_addr_stall();
        test_rst_mid();
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
